// File: rtl/ex_mem.sv
// EX/MEM pipeline register: carries the EX result into MEM and returns the
// multi-cycle multiply-accumulate partial state to EX while EX is stalled.
module ex_mem #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic                  ex_whilo,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [1:0]            cnt_i,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]     mem_mem_addr,
    output logic [DATA_W-1:0]     mem_reg2,
    output logic                  mem_whilo,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  mem_valid,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [1:0]            cnt_o
);

    logic [REG_ADDR_W-1:0] wd_q, wd_d;
    logic                  wreg_q, wreg_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [ALUOP_W-1:0]    aluop_q, aluop_d;
    logic [DATA_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     reg2_q, reg2_d;
    logic                  whilo_q, whilo_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic                  valid_q, valid_d;
    logic [2*DATA_W-1:0]   hilo_q, hilo_d;
    logic [1:0]            cnt_q, cnt_d;

    wire ex_stalled  = stall[3];
    wire mem_stalled = stall[4];

    always_comb begin
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        aluop_d = aluop_q;
        addr_d  = addr_q;
        reg2_d  = reg2_q;
        whilo_d = whilo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        valid_d = valid_q;
        hilo_d  = hilo_q;
        cnt_d   = cnt_q;
        if (flush || (ex_stalled && !mem_stalled)) begin
            // Flush and bubble both empty the MEM side; only a bubble keeps the MAC state.
            wd_d    = '0;
            wreg_d  = 1'b0;
            wdata_d = '0;
            aluop_d = '0;
            addr_d  = '0;
            reg2_d  = '0;
            whilo_d = 1'b0;
            hi_d    = '0;
            lo_d    = '0;
            valid_d = 1'b0;
            hilo_d  = flush ? '0 : hilo_i;
            cnt_d   = flush ? 2'd0 : cnt_i;
        end else if (!ex_stalled) begin
            wd_d    = ex_wd;
            wreg_d  = ex_wreg;
            wdata_d = ex_wdata;
            aluop_d = ex_aluop;
            addr_d  = ex_mem_addr;
            reg2_d  = ex_reg2;
            whilo_d = ex_whilo;
            hi_d    = ex_hi;
            lo_d    = ex_lo;
            valid_d = 1'b1;
            hilo_d  = '0;
            cnt_d   = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
            aluop_q <= '0;
            addr_q  <= '0;
            reg2_q  <= '0;
            whilo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
            hilo_q  <= '0;
            cnt_q   <= 2'd0;
        end else begin
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            aluop_q <= aluop_d;
            addr_q  <= addr_d;
            reg2_q  <= reg2_d;
            whilo_q <= whilo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            valid_q <= valid_d;
            hilo_q  <= hilo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_wd       = wd_q;
    assign mem_wreg     = wreg_q;
    assign mem_wdata    = wdata_q;
    assign mem_aluop    = aluop_q;
    assign mem_mem_addr = addr_q;
    assign mem_reg2     = reg2_q;
    assign mem_whilo    = whilo_q;
    assign mem_hi       = hi_q;
    assign mem_lo       = lo_q;
    assign mem_valid    = valid_q;
    assign hilo_o       = hilo_q;
    assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: stimulus pushes hand-computed expectations,
// a monitor pops and compares one record after each edge (or on demand).
module tb_ex_mem;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        valid;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0;
    logic [7:0]  ex_aluop = '0;
    logic [31:0] ex_mem_addr = '0;
    logic [31:0] ex_reg2 = '0;
    logic        ex_whilo = 1'b0;
    logic [31:0] ex_hi = '0;
    logic [31:0] ex_lo = '0;
    logic [63:0] hilo_i = '0;
    logic [1:0]  cnt_i = '0;

    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_valid;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    ex_mem dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_valid(mem_valid), .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    out_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    event  chk_ev;

    localparam out_t ZERO = '0;

    function automatic out_t mk(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                input logic [7:0] aluop, input logic [31:0] addr, input logic [31:0] reg2,
                                input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                                input logic valid, input logic [63:0] hilo, input logic [1:0] cnt);
        out_t o;
        o = '{wd, wreg, wdata, aluop, addr, reg2, whilo, hi, lo, valid, hilo, cnt};
        return o;
    endfunction

    task automatic push(input string nm, input out_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic clear_ex();
        ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_aluop = '0;
        ex_mem_addr = '0; ex_reg2 = '0; ex_whilo = 1'b0; ex_hi = '0; ex_lo = '0;
        hilo_i = '0; cnt_i = '0;
    endtask

    // Monitor: one record per rising edge, or per explicit trigger for between-edge checks.
    initial begin
        out_t  act, e;
        string nm;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = '{mem_wd, mem_wreg, mem_wdata, mem_aluop, mem_mem_addr, mem_reg2,
                        mem_whilo, mem_hi, mem_lo, mem_valid, hilo_o, cnt_o};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got wd=%h wreg=%b wdata=%h aluop=%h addr=%h reg2=%h whilo=%b hi=%h lo=%h valid=%b hilo=%h cnt=%0d ; want wd=%h wreg=%b wdata=%h aluop=%h addr=%h reg2=%h whilo=%b hi=%h lo=%h valid=%b hilo=%h cnt=%0d",
                             nm, act.wd, act.wreg, act.wdata, act.aluop, act.addr, act.reg2, act.whilo,
                             act.hi, act.lo, act.valid, act.hilo, act.cnt,
                             e.wd, e.wreg, e.wdata, e.aluop, e.addr, e.reg2, e.whilo,
                             e.hi, e.lo, e.valid, e.hilo, e.cnt);
                end else begin
                    $display("ok   %s: wd=%h wdata=%h valid=%b hilo=%h cnt=%0d",
                             nm, act.wd, act.wdata, act.valid, act.hilo, act.cnt);
                end
            end
        end
    end

    initial begin
        // Reset state while rst is held low, before any edge.
        #2;
        push("reset_state", ZERO);
        ->chk_ev;
        #2;

        @(negedge clk); rst = 1'b1;

        @(negedge clk); clear_ex(); stall = 6'b000000;
        ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h0000_FFFF;
        push("pass_through", mk(5'd5, 1'b1, 32'h0000_FFFF, 8'h00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0));

        @(negedge clk); stall = 6'b001111;
        ex_wd = 5'd7; ex_wdata = 32'h0000_1234; ex_whilo = 1'b1;
        hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
        push("bubble_1", mk(5'd0, 1'b0, 32'h0, 8'h00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0000_0001_0000_0002, 2'd1));

        @(negedge clk); hilo_i = 64'h0000_0003_0000_0004; cnt_i = 2'd2;
        push("bubble_2", mk(5'd0, 1'b0, 32'h0, 8'h00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0000_0003_0000_0004, 2'd2));

        @(negedge clk); clear_ex(); stall = 6'b000000;
        ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'hA5A5_A5A5;
        ex_whilo = 1'b1; ex_hi = 32'h0000_0011; ex_lo = 32'h0000_0022;
        hilo_i = 64'hFFFF_0000_FFFF_0000; cnt_i = 2'd3;
        push("advance_clears_mac", mk(5'd9, 1'b1, 32'hA5A5_A5A5, 8'h00, 32'h0, 32'h0, 1'b1, 32'h11, 32'h22, 1'b1, 64'h0, 2'd0));

        for (int i = 0; i < 3; i++) begin
            @(negedge clk); stall = 6'b011111;
            ex_wdata = 32'h1111_0000 + 32'(i); ex_wd = 5'd3; hilo_i = 64'(i + 1); cnt_i = 2'd1;
            push($sformatf("hold_%0d", i), mk(5'd9, 1'b1, 32'hA5A5_A5A5, 8'h00, 32'h0, 32'h0, 1'b1, 32'h11, 32'h22, 1'b1, 64'h0, 2'd0));
        end

        @(negedge clk); clear_ex(); stall = 6'b001111;
        hilo_i = 64'h0000_0000_0000_0005; cnt_i = 2'd1;
        push("bubble_before_hold", mk(5'd0, 1'b0, 32'h0, 8'h00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h5, 2'd1));

        @(negedge clk); stall = 6'b011111; hilo_i = 64'h9; cnt_i = 2'd3; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_FFFF;
        push("hold_keeps_mac", mk(5'd0, 1'b0, 32'h0, 8'h00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h5, 2'd1));

        @(negedge clk); stall = 6'b001111; flush = 1'b1; hilo_i = 64'h7777; cnt_i = 2'd2;
        push("flush_over_bubble", ZERO);

        @(negedge clk); flush = 1'b0; clear_ex(); stall = 6'b010000;
        ex_wd = 5'd31; ex_wreg = 1'b1; ex_wdata = 32'h0BAD_F00D;
        push("stall4_only_advance", mk(5'd31, 1'b1, 32'h0BAD_F00D, 8'h00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0));

        @(negedge clk); stall = 6'b000000; flush = 1'b1; ex_wdata = 32'h5555_5555;
        push("flush_over_advance", ZERO);

        @(negedge clk); flush = 1'b0; clear_ex();
        ex_aluop = 8'hEB; ex_mem_addr = 32'h8000_0010; ex_reg2 = 32'hDEAD_BEEF; ex_wreg = 1'b0;
        push("store_path", mk(5'd0, 1'b0, 32'h0, 8'hEB, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0));

        @(negedge clk); clear_ex(); ex_wd = 5'd2; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
        push("preload_for_reset", mk(5'd2, 1'b1, 32'h1234_5678, 8'h00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0));

        // Pull rst low mid-cycle; outputs must clear before the next edge.
        @(negedge clk); #1; rst = 1'b0;
        #1; push("async_reset", ZERO); ->chk_ev;

        @(negedge clk); rst = 1'b1; clear_ex(); stall = 6'b000000;
        ex_wd = 5'd4; ex_wreg = 1'b1; ex_wdata = 32'hCAFE_F00D;
        push("after_reset_load", mk(5'd4, 1'b1, 32'hCAFE_F00D, 8'h00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0));

        // Reset during a bubble must discard the partial MAC state.
        @(negedge clk); clear_ex(); stall = 6'b001111; hilo_i = 64'hABCD; cnt_i = 2'd2;
        push("bubble_before_reset", mk(5'd0, 1'b0, 32'h0, 8'h00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'hABCD, 2'd2));
        @(negedge clk); #1; rst = 1'b0;
        #1; push("reset_in_bubble", ZERO); ->chk_ev;
        @(negedge clk); rst = 1'b1; stall = 6'b000000; clear_ex();

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of register data, address and HI/LO words.
REQ-002 SHALL have parameter REG_ADDR_W, default 5: width of the destination register index.
REQ-003 SHALL have parameter ALUOP_W, default 8: width of the ALU operation code.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port stall  input  6  pipeline stall vector; bit 3 = EX stalled, bit 4 = MEM stalled.
REQ-007 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-008 SHALL have ports ex_wd (REG_ADDR_W), ex_wreg (1), ex_wdata (DATA_W)  input  EX result: destination index, write enable, write data.
REQ-009 SHALL have ports ex_aluop (ALUOP_W), ex_mem_addr (DATA_W), ex_reg2 (DATA_W)  input  load/store opcode, effective address, store data.
REQ-010 SHALL have ports ex_whilo (1), ex_hi (DATA_W), ex_lo (DATA_W)  input  HI/LO write enable and values.
REQ-011 SHALL have ports hilo_i (2*DATA_W), cnt_i (2)  input  multi-cycle multiply-accumulate partial product and step count from EX.
REQ-012 SHALL have ports mem_wd, mem_wreg, mem_wdata, mem_aluop, mem_mem_addr, mem_reg2, mem_whilo, mem_hi, mem_lo  output  registered copies of the matching ex_* inputs, same widths.
REQ-013 SHALL have port mem_valid  output  1  high when the MEM-side outputs hold a real instruction, low for a bubble.
REQ-014 SHALL have ports hilo_o (2*DATA_W), cnt_o (2)  output  partial product and step count returned to EX.

Function
REQ-015 SHALL evaluate the following in priority order on every rising clk edge while rst is high: flush, advance, bubble, hold.
REQ-016 Flush SHALL apply when flush=1, regardless of stall: all outputs take their reset values.
REQ-017 Advance SHALL apply when flush=0 and stall[3]=0: every mem_* output takes its ex_* input, mem_valid=1, hilo_o=0, cnt_o=0.
REQ-018 Bubble SHALL apply when flush=0, stall[3]=1 and stall[4]=0: all mem_* outputs are zero, mem_valid=0, hilo_o takes hilo_i, cnt_o takes cnt_i.
REQ-019 Hold SHALL apply when flush=0, stall[3]=1 and stall[4]=1: all outputs, including hilo_o and cnt_o, keep their values.
REQ-020 Stall vectors with stall[3]=0 and stall[4]=1 SHALL be treated as Advance; the stall controller never drives them.
REQ-021 Latency from the ex_* inputs to the mem_* outputs SHALL be exactly one clock when no stall or flush is active.
REQ-022 All outputs SHALL be driven directly from flops, with no combinational path from any input.
REQ-023 cnt_o and hilo_o SHALL be preserved across any number of consecutive Bubble cycles, so a multi-cycle multiply-accumulate in EX resumes with the correct partial state.
REQ-024 A flush arriving mid-accumulation SHALL clear cnt_o and hilo_o to zero.
REQ-025 mem_wreg=0 and mem_whilo=0 SHALL hold whenever mem_valid=0.

Reset
REQ-026 Asserting rst low SHALL, without waiting for clk, drive all mem_* outputs to zero and set mem_valid=0, hilo_o=0 and cnt_o=0.
REQ-027 Deasserting rst SHALL release the state; the first rising clk edge afterwards follows REQ-015.
REQ-028 Asserting rst low during a Hold or Bubble SHALL discard the held state immediately.

Verification
REQ-029 Pass-through: stall=0, ex_wd=5, ex_wreg=1, ex_wdata=0x0000_FFFF -> the next edge gives mem_wd=5, mem_wreg=1, mem_wdata=0x0000_FFFF, mem_valid=1.
REQ-030 Bubble: stall=6'b001111, hilo_i=0x0000_0001_0000_0002, cnt_i=1 -> mem_* outputs zero, mem_valid=0, hilo_o=0x0000_0001_0000_0002, cnt_o=1; a following stall=0 edge gives cnt_o=0, hilo_o=0.
REQ-031 Hold: latch ex_wdata=0xA5A5_A5A5, then apply stall=6'b011111 for 3 cycles while changing ex_wdata -> mem_wdata remains 0xA5A5_A5A5 and mem_valid remains 1.
REQ-032 Flush priority: flush=1 together with stall=6'b001111 and cnt_i=2 -> all outputs zero, cnt_o=0.
REQ-033 Asynchronous reset: with mem_wdata=0x1234_5678, pull rst low between clock edges -> all outputs zero before the next edge; release rst, then a stall=0 edge loads the new inputs.
REQ-034 Store path: ex_aluop = store-word opcode, ex_mem_addr=0x8000_0010, ex_reg2=0xDEAD_BEEF, ex_wreg=0 -> after one edge mem_aluop, mem_mem_addr and mem_reg2 match, mem_wreg=0, mem_valid=1.
